// File: rtl/truth_table_probe.sv
// Truth-table probe: sweeps 8 input vectors onto a 3-input gate and assembles its 8-bit hex code.
// Latency: start edge E0 -> done/table valid in the cycle after edge E0 + 8*(SETTLE_CYCLES+1).
// Backpressure: none; start is sampled only in IDLE, ignored otherwise (no queuing).
//
// Optional compare feature: define TT_COMPARE_EN to add the expected/mismatch ports.
// The table output is named table_code because "table" is a reserved Verilog keyword.
module truth_table_probe #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sense,
`ifdef TT_COMPARE_EN
    input  logic [7:0] expected,
    output logic       mismatch,
`endif
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_code
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Last counter value of the settle window; counter starts at 0 on SETTLE entry.
    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] v_q, v_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] table_q, table_d;
    logic [7:0] assembled;

`ifdef TT_COMPARE_EN
    logic [7:0] expected_q, expected_d;
    logic       mismatch_q, mismatch_d;
`endif

    // Final code: the bit of row 111 (bit 0) is the sense value captured on this very edge,
    // so table is loaded on the edge that enters DONE and is visible during the DONE cycle.
    assign assembled = {shreg_q[7:1], sense};

    // Next-state, vector/counter sequencing and capture of sense into bit (7 - v).
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        table_d = table_q;
`ifdef TT_COMPARE_EN
        expected_d = expected_q;
        mismatch_d = mismatch_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    v_d     = 3'd0;
                    cnt_d   = 8'd0;
                    shreg_d = 8'd0;
`ifdef TT_COMPARE_EN
                    expected_d = expected;
`endif
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SAMPLE: begin
                shreg_d[3'd7 - v_q] = sense;
                if (v_q == 3'd7) begin
                    state_d = DONE;
                    table_d = assembled;
`ifdef TT_COMPARE_EN
                    mismatch_d = (assembled != expected_q);
`endif
                end else begin
                    state_d = SETTLE;
                    v_d     = v_q + 3'd1;
                    cnt_d   = 8'd0;
                end
            end
            DONE: begin
                state_d = IDLE;
                v_d     = 3'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            v_q     <= 3'd0;
            cnt_q   <= 8'd0;
            shreg_q <= 8'd0;
            table_q <= 8'd0;
`ifdef TT_COMPARE_EN
            expected_q <= 8'd0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            table_q <= table_d;
`ifdef TT_COMPARE_EN
            expected_q <= expected_d;
            mismatch_q <= mismatch_d;
`endif
        end
    end

    // Outputs decode straight from registered state, so they are glitch-free towards the gate.
    always_comb begin
        busy            = (state_q == SETTLE) || (state_q == SAMPLE);
        done            = (state_q == DONE);
        {in1, in2, in3} = busy ? v_q : 3'b000;
        table_code      = table_q;
`ifdef TT_COMPARE_EN
        mismatch        = mismatch_q;
`endif
    end

endmodule
